// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the memory-side responder.
package mem_pkg;

  typedef enum logic [1:0] {
    MR_IDLE = 2'd0,
    MR_WAIT = 2'd1,
    MR_DONE = 2'd2
  } mem_resp_state_t;

  localparam int WORD_BYTES = 4;

  // Keep the bytes whose select bit is set, zero the rest.
  function automatic logic [31:0] mask_bytes(input logic [31:0] data, input logic [3:0] sel);
    logic [31:0] res;
    res = 32'h0000_0000;
    for (int i = 0; i < WORD_BYTES; i++) begin
      res[8*i +: 8] = sel[i] ? data[8*i +: 8] : 8'h00;
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the bus arbiter (master) and the memory responder (slave).
interface mem_responder_if;
  logic        write_to_mem;
  logic        read_to_mem;
  logic [31:0] adr_to_mem;
  logic [31:0] data_to_mem;
  logic [3:0]  sel_to_mem;
  logic [31:0] data_from_mem;
  logic        mem_busy;
  logic        mem_done;
  logic        adr_err;

  modport master (
    output write_to_mem, read_to_mem, adr_to_mem, data_to_mem, sel_to_mem,
    input  data_from_mem, mem_busy, mem_done, adr_err
  );

  modport slave (
    input  write_to_mem, read_to_mem, adr_to_mem, data_to_mem, sel_to_mem,
    output data_from_mem, mem_busy, mem_done, adr_err
  );
endinterface

// File: rtl/mem_responder_mem_array.sv
// Word storage with per-byte write enables and a registered read port.
module mem_array #(
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_wr_idx,
  input  logic [31:0]   i_wr_data,
  input  logic [AW-1:0] i_rd_idx,
  output logic [31:0]   o_rd_data
);

  logic [31:0] r_mem [DEPTH];

  // Byte-masked write and synchronous read; contents survive reset.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_we[i]) begin
        r_mem[i_wr_idx][8*i +: 8] <= i_wr_data[8*i +: 8];
      end
    end
    o_rd_data <= r_mem[i_rd_idx];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one read/write, waits a fixed latency, then strobes completion.
module mem_responder
  import mem_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LATENCY   = 2
) (
  input logic            i_clk,
  input logic            i_rst,
  mem_responder_if.slave bus
);

  localparam int          AW   = $clog2(DEPTH);
  localparam int          CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [32:0] SPAN = 33'(DEPTH) * 33'(WORD_BYTES);

  mem_resp_state_t r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_adr, r_data, r_rd_data;
  logic [3:0]      r_sel, w_we;
  logic            r_wr, r_done, r_err;
  logic            w_req, w_accept, w_last, w_busy, w_in_range;
  logic [31:0]     w_offset, w_in_offset, w_q;
  logic [AW-1:0]   w_wr_idx, w_rd_idx;

  assign w_req       = bus.write_to_mem | bus.read_to_mem;
  assign w_offset    = r_adr - BASE_ADDR;
  assign w_in_offset = bus.adr_to_mem - BASE_ADDR;
  assign w_in_range  = (r_adr >= BASE_ADDR) && ({1'b0, w_offset} < SPAN);
  assign w_wr_idx    = AW'(w_offset >> 2);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= MR_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      MR_IDLE: begin
        if (w_req) w_next = MR_WAIT;
        else       w_next = MR_IDLE;
      end
      MR_WAIT: begin
        if (r_cnt == CW'(0)) w_next = MR_DONE;
        else                 w_next = MR_WAIT;
      end
      MR_DONE: w_next = MR_IDLE;
      default: w_next = MR_IDLE;
    endcase
  end

  // FSM-derived controls; the array read address tracks the live bus while idle so LATENCY=1 works.
  always_comb begin
    w_busy   = (r_state != MR_IDLE);
    w_accept = (r_state == MR_IDLE) && w_req;
    w_last   = (r_state == MR_WAIT) && (r_cnt == CW'(0));
    if (r_state == MR_IDLE) begin
      w_rd_idx = AW'(w_in_offset >> 2);
    end else begin
      w_rd_idx = w_wr_idx;
    end
    if (w_last && r_wr && w_in_range && !i_rst) begin
      w_we = r_sel;
    end else begin
      w_we = 4'b0000;
    end
  end

  // Capture, latency counter, completion flags and read data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= CW'(0);
      r_adr     <= 32'h0000_0000;
      r_data    <= 32'h0000_0000;
      r_sel     <= 4'b0000;
      r_wr      <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_rd_data <= 32'h0000_0000;
    end else begin
      r_done <= w_last;
      r_err  <= w_last && !w_in_range;
      if (w_accept) begin
        r_cnt  <= CW'(LATENCY - 1);
        r_adr  <= bus.adr_to_mem;
        r_data <= bus.data_to_mem;
        r_sel  <= bus.sel_to_mem;
        r_wr   <= bus.write_to_mem;
      end else if (r_state == MR_WAIT && r_cnt != CW'(0)) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_last && !r_wr) begin
        r_rd_data <= w_in_range ? mask_bytes(w_q, r_sel) : 32'h0000_0000;
      end
    end
  end

  mem_array #(.DEPTH(DEPTH)) u_mem_array (
    .i_clk     (i_clk),
    .i_we      (w_we),
    .i_wr_idx  (w_wr_idx),
    .i_wr_data (r_data),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_q)
  );

  assign bus.data_from_mem = r_rd_data;
  assign bus.mem_busy      = w_busy;
  assign bus.mem_done      = r_done;
  assign bus.adr_err       = r_err;

endmodule
